// File: rtl/pattern_sequencer_if.sv
// Bundle of the game-flow signals exchanged between pattern_sequencer and
// its surroundings (random block, button decoder, display layer).
//
// Handshakes:
//   start, btn_valid : single-cycle pulses from the environment; each high
//                      cycle is one event, sampled on the rising clk edge.
//   rand_step/rand_ready : the sequencer holds rand_step=4'b0001 while it
//                      wants a value; the first edge with rand_ready=1
//                      completes the request and rand_step drops to 0. The
//                      random block must hold rand_num stable for the
//                      following cycle, when it is sampled.
//   show_valid       : level signal; show_code is meaningful only while it
//                      is high and reads 0 otherwise.
// dbg_state exposes the sequencer's FSM state for checkers.
interface pattern_sequencer_if #(
  parameter int MAX_LEN = 16
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic          start;
  logic [3:0]    rand_step;
  logic [2:0]    rand_num;
  logic          rand_ready;
  logic          btn_valid;
  logic [2:0]    btn_code;
  logic          show_valid;
  logic [2:0]    show_code;
  logic [LW-1:0] level;
  logic          busy;
  logic          win;
  logic          lose;
  logic [2:0]    dbg_state;

  modport master (
    input  start, rand_num, rand_ready, btn_valid, btn_code,
    output rand_step, show_valid, show_code, level, busy, win, lose, dbg_state
  );

  modport slave (
    output start, rand_num, rand_ready, btn_valid, btn_code,
    input  rand_step, show_valid, show_code, level, busy, win, lose, dbg_state
  );
endinterface

// File: rtl/pattern_sequencer.sv
// Memory-pattern game controller: grows a random symbol pattern by one per
// round, replays it to the display, then checks the player's button entries.
// All outputs come straight from flops, so nothing combinational reaches the
// display from any input.
module pattern_sequencer #(
  parameter int MAX_LEN     = 16,
  parameter int SHOW_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 12_500_000
) (
  input  logic             clk,
  input  logic             rst,
  pattern_sequencer_if.master bus
);

  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  // Timer counts down from N-1 to 0, giving exactly N cycles in the state.
  localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    CAPT     = 3'd2,
    SHOW_ON  = 3'd3,
    SHOW_OFF = 3'd4,
    INPUT    = 3'd5,
    WIN      = 3'd6,
    LOSE     = 3'd7
  } state_t;

  state_t        state;
  logic [LW-1:0] level_r;
  logic [LW-1:0] idx;
  logic [TW-1:0] timer;
  logic [2:0]    buffer [MAX_LEN];

  logic [3:0]    step_r;
  logic          show_v;
  logic [2:0]    show_c;
  logic          busy_r;
  logic          win_r;
  logic          lose_r;

  logic [LW-1:0] idx_inc;
  logic [LW-1:0] level_m1;
  logic          at_last;
  logic          at_max;
  logic          rand_ok;
  logic          btn_hit;

  assign idx_inc  = idx + LW'(1);
  assign level_m1 = level_r - LW'(1);
  assign at_last  = (idx == level_m1);
  assign at_max   = (level_r == LW'(MAX_LEN));
  assign rand_ok  = (bus.rand_num >= 3'd1) && (bus.rand_num <= 3'd4);
  assign btn_hit  = (bus.btn_code == buffer[idx[AW-1:0]]);

  // Pattern storage: one new symbol is appended at the accepted capture.
  always_ff @(posedge clk) begin
    if (state == CAPT && rand_ok) begin
      buffer[level_r[AW-1:0]] <= bus.rand_num;
    end
  end

  // Game FSM; each transition also sets the registered outputs of the
  // state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      level_r <= '0;
      idx     <= '0;
      timer   <= '0;
      step_r  <= 4'b0000;
      show_v  <= 1'b0;
      show_c  <= 3'd0;
      busy_r  <= 1'b0;
      win_r   <= 1'b0;
      lose_r  <= 1'b0;
    end else begin
      case (state)
        IDLE, WIN, LOSE: begin
          if (bus.start) begin
            state   <= REQ;
            level_r <= '0;
            idx     <= '0;
            timer   <= '0;
            step_r  <= 4'b0001;
            busy_r  <= 1'b1;
            win_r   <= 1'b0;
            lose_r  <= 1'b0;
          end
        end

        REQ: begin
          if (bus.rand_ready) begin
            state  <= CAPT;
            timer  <= '0;
            step_r <= 4'b0000;
          end
        end

        // One-cycle bubble: rand_num is sampled at the edge leaving CAPT.
        CAPT: begin
          if (rand_ok) begin
            state   <= SHOW_ON;
            level_r <= level_r + LW'(1);
            idx     <= '0;
            timer   <= SHOW_LOAD;
            show_v  <= 1'b1;
            // On the first round buffer[0] is being written this very edge.
            show_c  <= (level_r == '0) ? bus.rand_num : buffer[0];
          end else begin
            state  <= REQ;
            timer  <= '0;
            step_r <= 4'b0001;
          end
        end

        SHOW_ON: begin
          if (timer == '0) begin
            state  <= SHOW_OFF;
            timer  <= GAP_LOAD;
            show_v <= 1'b0;
            show_c <= 3'd0;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        SHOW_OFF: begin
          if (timer == '0) begin
            if (at_last) begin
              state <= INPUT;
              idx   <= '0;
              timer <= '0;
            end else begin
              state  <= SHOW_ON;
              idx    <= idx_inc;
              timer  <= SHOW_LOAD;
              show_v <= 1'b1;
              show_c <= buffer[idx_inc[AW-1:0]];
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end

        // No timeout: the player may take as long as they like.
        INPUT: begin
          if (bus.btn_valid) begin
            if (!btn_hit) begin
              state  <= LOSE;
              timer  <= '0;
              busy_r <= 1'b0;
              lose_r <= 1'b1;
            end else if (!at_last) begin
              idx <= idx_inc;
            end else if (at_max) begin
              state  <= WIN;
              timer  <= '0;
              busy_r <= 1'b0;
              win_r  <= 1'b1;
            end else begin
              state  <= REQ;
              idx    <= '0;
              timer  <= '0;
              step_r <= 4'b0001;
            end
          end
        end

        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          step_r <= 4'b0000;
          show_v <= 1'b0;
          show_c <= 3'd0;
        end
      endcase
    end
  end

  assign bus.rand_step  = step_r;
  assign bus.show_valid = show_v;
  assign bus.show_code  = show_c;
  assign bus.level      = level_r;
  assign bus.busy       = busy_r;
  assign bus.win        = win_r;
  assign bus.lose       = lose_r;
  assign bus.dbg_state  = state;

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Game-flow controller for the memory-pattern game on the VGA path. It drives the random number block's step input and captures one new symbol (1–4) per round into an internal pattern buffer. It replays the stored pattern to the display layer, then checks the player's button entries against it. The block owns round and level progression and the win/lose outcome; the display logic only consumes `show_valid`/`show_code` and the status flags.

## Interface
- `MAX_LEN`, default 16: pattern buffer depth; reaching this level with a correct entry is a win.
- `SHOW_CYCLES`, default 25_000_000: clocks each symbol is displayed.
- `GAP_CYCLES`, default 12_500_000: blank clocks after each displayed symbol.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle pulse; begins a new game.
- `rand_step`  out  4  step input to the random block; 4'b0001 requests a value, otherwise 4'b0000.
- `rand_num`  in  3  value from the random block.
- `rand_ready`  in  1  random block ready flag.
- `btn_valid`  in  1  single-cycle pulse; player pressed a button.
- `btn_code`  in  3  button symbol, 1–4, valid with `btn_valid`.
- `show_valid`  out  1  high while a pattern symbol is to be drawn.
- `show_code`  out  3  symbol being shown; 0 when `show_valid` is low.
- `level`  out  $clog2(MAX_LEN+1)  current pattern length.
- `busy`  out  1  high in every state except IDLE, WIN and LOSE.
- `win`  out  1  high in WIN.
- `lose`  out  1  high in LOSE.

## Operation
- States: IDLE, REQ, CAPT, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE.
- Reset: the FSM goes to IDLE. `level`=0, index=0, timer=0. All outputs are 0, including `rand_step`=4'b0000. Buffer contents are don't-care.
- IDLE, WIN, LOSE → REQ on `start`. Taking this transition sets `level`=0 and index=0. `start` is ignored in all other states.
- REQ: `rand_step`=4'b0001. Stay until `rand_ready`=1, then go to CAPT.
- CAPT: `rand_step`=4'b0000 for exactly 1 cycle. This lets the random block's registered output settle. On the following clock edge, sample `rand_num`:
  - If the value is in 1..4, write it to buffer[`level`], increment `level`, set index=0, and go to SHOW_ON.
  - If the value is 0 or >4, discard it and go to REQ.
- SHOW_ON: `show_valid`=1 and `show_code`=buffer[index] for SHOW_CYCLES clocks, then go to SHOW_OFF.
- SHOW_OFF: `show_valid`=0 for GAP_CYCLES clocks.
  - If index==`level`-1, set index=0 and go to INPUT.
  - Otherwise increment index and go to SHOW_ON.
- INPUT: on `btn_valid`, compare `btn_code` with buffer[index]:
  - Mismatch → LOSE.
  - Match with index<`level`-1 → increment index.
  - Match with index==`level`-1: if `level`==MAX_LEN go to WIN, else go to REQ.
- `btn_valid` is ignored outside INPUT. There is no input timeout.
- `level` holds its value in WIN and LOSE so it can be displayed as a score.

## Timing
- All outputs are registered, decoded from the state register and buffer; no combinational path from inputs to outputs.
- The `start` edge puts the FSM in REQ, so `rand_step` is 4'b0001 in the next cycle.
- REQ→CAPT occurs on the first edge where `rand_ready`=1. There is a 1-cycle bubble in CAPT, then capture.
- Minimum `start`-to-first-`show_valid` latency: 3 clocks, with `rand_ready` already high.
- Each displayed symbol occupies exactly SHOW_CYCLES+GAP_CYCLES clocks. The timer reloads on every state entry.
- `btn_valid` pulses on consecutive cycles are each evaluated, one per cycle.
- An `rst` assertion mid-game (any state, including mid-SHOW) returns the block to the reset values immediately. `show_valid` drops asynchronously.

## Test plan
Use parameters MAX_LEN=4, SHOW_CYCLES=4, GAP_CYCLES=2 and a behavioural random-block model.
- Reset, then idle 10 cycles → all outputs 0, `rand_step`=0, `level`=0, `busy`=0.
- `start` pulse with model returning 3 → `rand_step`=1 until `rand_ready`, capture 3, `level`=1. `show_valid` high 4 cycles with `show_code`=3, then low 2 cycles, then INPUT.
- Model returns 0, then 2 on re-request → first value discarded, a second REQ is issued, buffer[0]=2, `level`=1.
- Full game with sequence 1,4,2,3 and correct entries each round → replay lengths 1,2,3,4, each symbol in order. After the 4th correct entry, `win`=1, `busy`=0, `level`=4.
- At `level`=2 with pattern 1,4, press 1 then 2 → `lose`=1 on the cycle after the second press, `level` stays 2. A subsequent `start` gives `level`=0 and `busy`=1.
- Assert `rst` during SHOW_ON of round 3 → `show_valid`=0 and `level`=0 immediately, FSM in IDLE. `btn_valid` pulses afterwards have no effect.
